mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and access sequencer for the single unified instruction/data memory of the multicycle core. It shares the memory between the CPU port, driven by the main control FSM during fetch and load/store states, and a DMA/loader port. It latches the granted request and holds the memory interface stable until the memory acknowledges. It then returns read data with a one-cycle ready pulse. The core FSM stalls on `cpu_ready`.

## Interface
Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 15: maximum wait cycles in BUSY before abort. Range 1..255. Used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  CPU access request; held high until `cpu_ready`.
- `cpu_we`  in  1  CPU write enable; 1 = store.
- `cpu_adr`  in  AW  CPU address.
- `cpu_wd`  in  DW  CPU write data.
- `cpu_rd`  out  DW  CPU read data; valid while `cpu_ready` = 1.
- `cpu_ready`  out  1  one-cycle completion pulse to the CPU.
- `cpu_err`  out  1  timeout flag; coincident with `cpu_ready`.
- `dma_req`, `dma_we`, `dma_adr`, `dma_wd`, `dma_rd`, `dma_ready`, `dma_err`: same widths and meanings as the CPU set, for the DMA port.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_adr`  out  AW  memory address.
- `mem_wd`  out  DW  memory write data.
- `mem_rd`  in  DW  memory read data; sampled when `mem_ack` = 1.
- `mem_ack`  in  1  one-cycle access-done pulse from memory.

## Operation
- States:
  - IDLE: `mem_en` = 0.
  - BUSY: `mem_en` = 1; `mem_we`, `mem_adr`, `mem_wd` come from registers latched at grant.
  - DONE: the grantee's ready = 1 for one cycle.
- IDLE → BUSY when `cpu_req` or `dma_req` = 1. Grant selection:
  - Only one requester active: grant it.
  - Both active: grant the port not in `last_grant`.
  - On grant: `last_grant` ← grantee; latch `we`/`adr`/`wd` from the grantee; clear the wait counter.
- BUSY → DONE when `mem_ack` = 1.
  - Capture `mem_rd` into the read-data register. Writes capture it too; the value is don't-care.
  - err ← 0.
- DONE → IDLE unconditionally.
- Ready, err, and the read-data register route to the grantee only. The non-grantee's ready and err stay 0.
- Requests are sampled only in IDLE. Requests arriving during BUSY/DONE wait; request lines are never latched as events.
- Requester rules:
  - Hold req, we, adr, wd stable until ready.
  - Drop req in the cycle after ready if there is no further access. If req stays high, a new access is arbitrated.
- `mem_ack` outside BUSY is ignored.
- `rd` outputs hold their last value between accesses.
- Reset, at any time including mid-BUSY, forces:
  - state = IDLE; all outputs 0.
  - `last_grant` = DMA, so the CPU wins the first tie.
  - wait counter 0; the in-flight access is dropped with no ready.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Minimum latency: req high in IDLE at cycle 0 → `mem_en` at cycle 1 → `mem_ack` in cycle 1 → ready at cycle 2. Next grant at the earliest in cycle 4 (IDLE at cycle 3).
- Each memory wait cycle adds one cycle of latency.
- With both requesters continuously active, grants alternate strictly: CPU, DMA, CPU, …. One access per 3 + wait cycles.
- Wait counter is 8 bits, saturating, and increments in each BUSY cycle without `mem_ack`.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - If the wait counter reaches `TIMEOUT` in BUSY with no ack, go to DONE with err = 1, read data = 0, and deassert `mem_en`.
  - `mem_ack` in the same cycle as the timeout wins: normal completion, err = 0.
- Undefined: no counter logic; BUSY waits indefinitely; `cpu_err` and `dma_err` are tied 0.

## Test plan
- Reset mid-BUSY (CPU access at 0x40, no ack) → next cycle `mem_en` = 0 and all outputs 0; no `cpu_ready` is ever issued for that access.
- CPU read 0x100, memory acks in the first BUSY cycle with 0xDEADBEEF → `cpu_ready` at cycle 2 with `cpu_rd` = 0xDEADBEEF; `dma_ready` stays 0.
- DMA write 0x20 ← 0x12345678 with 3 wait cycles → `mem_we` = 1, `mem_adr` = 0x20, `mem_wd` = 0x12345678 held for 4 BUSY cycles; `dma_ready` at cycle 5.
- Both requesters held high for 4 accesses, 0-wait memory → grant order CPU, DMA, CPU, DMA; ready pulses at cycles 2, 5, 8, 11.
- `ARB_TIMEOUT_EN`, `TIMEOUT` = 4, CPU read, no ack → `mem_en` high for 4 cycles; `cpu_ready` = 1, `cpu_err` = 1, `cpu_rd` = 0 at cycle 5; the next access completes with err = 0.
- `ARB_TIMEOUT_EN`, `TIMEOUT` = 4, `mem_ack` arrives in the 4th BUSY cycle with 0xA5A5A5A5 → normal completion: `cpu_err` = 0, `cpu_rd` = 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the CPU port, DMA port and memory port of mem_port_arbiter.
//   slave  : arbiter view (takes requests and memory replies, drives
//            ready/err/rd and the memory strobe/address/data).
//   master : environment view (requesters and memory model).
// Parameters: AW address width, DW data width.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          cpu_ready;
    logic          cpu_err;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_adr;
    logic [DW-1:0] dma_wd;
    logic [DW-1:0] dma_rd;
    logic          dma_ready;
    logic          dma_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wd,
        output cpu_rd, cpu_ready, cpu_err,
        input  dma_req, dma_we, dma_adr, dma_wd,
        output dma_rd, dma_ready, dma_err,
        output mem_en, mem_we, mem_adr, mem_wd,
        input  mem_rd, mem_ack
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wd,
        input  cpu_rd, cpu_ready, cpu_err,
        output dma_req, dma_we, dma_adr, dma_wd,
        input  dma_rd, dma_ready, dma_err,
        input  mem_en, mem_we, mem_adr, mem_wd,
        output mem_rd, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified instruction/data memory between the CPU port and a
// DMA/loader port. A request seen in IDLE is granted (alternating on a tie),
// its we/adr/wd are latched and held on the memory port until mem_ack, then
// the grantee gets a one-cycle ready pulse with the captured read data.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : mem_port_arbiter_if.slave (cpu_*, dma_*, mem_* signals)
// Parameters: AW, DW widths; TIMEOUT (1..255) wait limit in BUSY.
// Optional feature: define ARB_TIMEOUT_EN to abort an access after TIMEOUT
// BUSY cycles without mem_ack (ready with err=1, rd=0). Without it BUSY waits
// indefinitely and cpu_err/dma_err are tied low.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic          last_dma;   // 1: DMA held the most recent grant
    logic          grant_dma;  // grantee of the access in flight
    logic          pick_dma;
    logic          sel_we;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_wd;

    // On a tie the port that did not win last time gets the grant.
    assign pick_dma = bus.dma_req && (!bus.cpu_req || !last_dma);
    assign sel_we   = pick_dma ? bus.dma_we  : bus.cpu_we;
    assign sel_adr  = pick_dma ? bus.dma_adr : bus.cpu_adr;
    assign sel_wd   = pick_dma ? bus.dma_wd  : bus.cpu_wd;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
`else
    assign bus.cpu_err = 1'b0;
    assign bus.dma_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_dma      <= 1'b1;
            grant_dma     <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_adr   <= '0;
            bus.mem_wd    <= '0;
            bus.cpu_rd    <= '0;
            bus.dma_rd    <= '0;
            bus.cpu_ready <= 1'b0;
            bus.dma_ready <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus.cpu_err   <= 1'b0;
            bus.dma_err   <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            // ready/err are single-cycle pulses asserted only in DONE
            bus.cpu_ready <= 1'b0;
            bus.dma_ready <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus.cpu_err   <= 1'b0;
            bus.dma_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        state       <= BUSY;
                        grant_dma   <= pick_dma;
                        last_dma    <= pick_dma;
                        bus.mem_en  <= 1'b1;
                        bus.mem_we  <= sel_we;
                        bus.mem_adr <= sel_adr;
                        bus.mem_wd  <= sel_wd;
`ifdef ARB_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        state      <= DONE;
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        if (grant_dma) begin
                            bus.dma_ready <= 1'b1;
                            bus.dma_rd    <= bus.mem_rd;
                        end else begin
                            bus.cpu_ready <= 1'b1;
                            bus.cpu_rd    <= bus.mem_rd;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // This cycle would bring the count to TIMEOUT: abort.
                    else if (wait_cnt >= TO_LIM) begin
                        state      <= DONE;
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        if (grant_dma) begin
                            bus.dma_ready <= 1'b1;
                            bus.dma_err   <= 1'b1;
                            bus.dma_rd    <= '0;
                        end else begin
                            bus.cpu_ready <= 1'b1;
                            bus.cpu_err   <= 1'b1;
                            bus.cpu_rd    <= '0;
                        end
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
